// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one two-stage ALU between NREQ lanes.
// Supports a per-lane lock for back-to-back issue and tags each op with
// its lane ID through the fixed 2-cycle ALU latency.
module alu_arbiter #(
   parameter int NREQ     = 4,
   parameter int IDW      = 2,
   parameter int LOCK_MAX = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_lock,
   input  logic [16*NREQ-1:0]   req_pc,
   input  logic [16*NREQ-1:0]   req_ins,
   input  logic [16*NREQ-1:0]   req_op1,
   input  logic [16*NREQ-1:0]   req_op2,
   output logic [NREQ-1:0]      gnt,
   output logic [15:0]          alu_pc,
   output logic [15:0]          alu_ins,
   output logic [15:0]          alu_op1,
   output logic [15:0]          alu_op2,
   input  logic [15:0]          alu_result,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [15:0]          rsp_data,
   output logic                 locked
);

   localparam int CW = $clog2(LOCK_MAX + 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]     state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] owner;
   logic [CW-1:0]  idle_cnt;

   logic           gnt_any;
   logic [IDW-1:0] gid;
   logic [IDW-1:0] cand;
   logic [IDW-1:0] gid_next;
   logic [IDW-1:0] owner_next;

   logic           s1_v, s2_v;
   logic [IDW-1:0] s1_id, s2_id;

   assign gid_next   = IDW'((32'(gid) + 32'd1) % 32'(NREQ));
   assign owner_next = IDW'((32'(owner) + 32'd1) % 32'(NREQ));

   // Grant selection: owner-only while locked, round-robin from ptr otherwise
   always_comb begin
      gnt     = '0;
      gid     = '0;
      gnt_any = 1'b0;
      cand    = '0;
      if (!reset) begin
         if (state == ST_LOCKED) begin
            if (req[owner]) begin
               gnt[owner] = 1'b1;
               gid        = owner;
               gnt_any    = 1'b1;
            end
         end else begin
            for (int unsigned k = 0; k < 32'(NREQ); k++) begin
               cand = IDW'((32'(ptr) + k) % 32'(NREQ));
               if (!gnt_any && req[cand]) begin
                  gnt[cand] = 1'b1;
                  gid       = cand;
                  gnt_any   = 1'b1;
               end
            end
         end
      end
   end

   // ALU operand mux; idle cycles issue ADD 0,0 whose result is dropped
   always_comb begin
      alu_pc  = '0;
      alu_ins = '0;
      alu_op1 = '0;
      alu_op2 = '0;
      if (gnt_any) begin
         alu_pc  = req_pc [16*int'(gid) +: 16];
         alu_ins = req_ins[16*int'(gid) +: 16];
         alu_op1 = req_op1[16*int'(gid) +: 16];
         alu_op2 = req_op2[16*int'(gid) +: 16];
      end
   end

   // Arbitration state: round-robin pointer, lock ownership, idle timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         owner    <= '0;
         idle_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (gnt_any) begin
            if (req_lock[gid]) begin
               state    <= ST_LOCKED;
               owner    <= gid;
               idle_cnt <= '0;
            end else begin
               ptr <= gid_next;
            end
         end
      end else begin
         // An owner grant takes priority over the idle timeout
         if (gnt_any) begin
            idle_cnt <= '0;
            if (!req_lock[owner]) begin
               state <= ST_IDLE;
               ptr   <= owner_next;
            end
         end else if (idle_cnt == CW'(LOCK_MAX - 1)) begin
            state    <= ST_IDLE;
            ptr      <= owner_next;
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + CW'(1);
         end
      end
   end

   // Lane-ID tag pipeline matching the two ALU stages
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v  <= 1'b0;
         s1_id <= '0;
         s2_v  <= 1'b0;
         s2_id <= '0;
      end else begin
         s1_v  <= gnt_any;
         s1_id <= gid;
         s2_v  <= s1_v;
         s2_id <= s1_id;
      end
   end

   assign rsp_valid = s2_v;
   assign rsp_id    = s2_id;
   assign rsp_data  = alu_result;
   assign locked    = (state == ST_LOCKED);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a two-stage ALU stand-in
// (ins 16'h0001 = SUB, anything else = ADD).
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req, req_lock, gnt;
   logic [63:0] req_pc, req_ins, req_op1, req_op2;
   logic [15:0] alu_pc, alu_ins, alu_op1, alu_op2, alu_result;
   logic        rsp_valid, locked;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic [15:0] x1, x2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(4), .IDW(2), .LOCK_MAX(15)) dut (
      .clk(clk), .reset(reset), .req(req), .req_lock(req_lock),
      .req_pc(req_pc), .req_ins(req_ins), .req_op1(req_op1), .req_op2(req_op2),
      .gnt(gnt), .alu_pc(alu_pc), .alu_ins(alu_ins), .alu_op1(alu_op1),
      .alu_op2(alu_op2), .alu_result(alu_result), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .locked(locked)
   );

   // Two-stage ALU stand-in
   always @(posedge clk) begin
      x1 <= (alu_ins == 16'h0001) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
      x2 <= x1;
   end
   assign alu_result = x2;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [15:0] pc, input logic [15:0] ins,
                           input logic [15:0] a, input logic [15:0] b);
      req_pc [16*i +: 16] = pc;
      req_ins[16*i +: 16] = ins;
      req_op1[16*i +: 16] = a;
      req_op2[16*i +: 16] = b;
   endtask

   task automatic do_reset;
      reset = 1'b1; req = '0; req_lock = '0;
      step;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; req = 4'b1111; req_lock = '0;
      for (int i = 0; i < 4; i++) set_lane(i, 16'h1000 + 16'(i), 16'h0005, 16'h0009, 16'h0002);
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", gnt); end
      checks++; if (alu_op1 !== 16'h0) begin errors++; $display("FAIL rst_alu_op1 got %h exp 0000", alu_op1); end
      checks++; if (alu_ins !== 16'h0) begin errors++; $display("FAIL rst_alu_ins got %h exp 0000", alu_ins); end
      step; step;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp_id got %0d exp 0", rsp_id); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", locked); end
      req = '0;
   endtask

   task automatic test_single_add;
      do_reset;
      set_lane(0, 16'h0100, 16'h0000, 16'd3, 16'd4);
      req = 4'b0001; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL add_gnt got %b exp 0001", gnt); end
      checks++; if (alu_op1 !== 16'd3 || alu_op2 !== 16'd4 || alu_pc !== 16'h0100)
         begin errors++; $display("FAIL add_alu_in got %h %h %h exp 0003 0004 0100", alu_op1, alu_op2, alu_pc); end
      step; req = '0; #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", rsp_valid); end
      step;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd7)
         begin errors++; $display("FAIL add_rsp got v%b id%0d %h exp v1 id0 0007", rsp_valid, rsp_id, rsp_data); end
      step;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_late_valid got %b exp 0", rsp_valid); end
   endtask

   task automatic test_round_robin;
      logic [3:0]  eg;
      logic [1:0]  eid;
      logic [15:0] ed;
      do_reset;
      for (int i = 0; i < 4; i++) set_lane(i, 16'h0200 + 16'(i), 16'h0000, 16'(i * 10), 16'd1);
      for (int c = 0; c < 10; c++) begin
         req = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         eg = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
         checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt c%0d got %b exp %b", c, gnt, eg); end
         if (c >= 2) begin
            eid = 2'((c - 2) % 4);
            ed  = 16'(((c - 2) % 4) * 10 + 1);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== ed)
               begin errors++; $display("FAIL rr_rsp c%0d got v%b id%0d %h exp v1 id%0d %h", c, rsp_valid, rsp_id, rsp_data, eid, ed); end
         end
         step;
      end
   endtask

   task automatic test_lock_chain;
      do_reset;
      for (int i = 0; i < 4; i++) set_lane(i, 16'h0300 + 16'(i), 16'h0000, 16'(i), 16'd0);
      req = 4'b0010; #1;   // move ptr to 2
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lk_pre_gnt got %b exp 0010", gnt); end
      step;
      req = 4'b1101; req_lock = 4'b0100; #1;
      checks++; if (gnt !== 4'b0100 || locked !== 1'b0) begin errors++; $display("FAIL lk_op1 got %b L%b exp 0100 L0", gnt, locked); end
      step; #1;
      checks++; if (gnt !== 4'b0100 || locked !== 1'b1) begin errors++; $display("FAIL lk_op2 got %b L%b exp 0100 L1", gnt, locked); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL lk_rsp_a got v%b id%0d exp v1 id1", rsp_valid, rsp_id); end
      step; #1;
      checks++; if (gnt !== 4'b0100 || locked !== 1'b1) begin errors++; $display("FAIL lk_op3 got %b L%b exp 0100 L1", gnt, locked); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL lk_rsp_b got v%b id%0d exp v1 id2", rsp_valid, rsp_id); end
      step;
      req_lock = 4'b0000; #1;
      checks++; if (gnt !== 4'b0100 || locked !== 1'b1) begin errors++; $display("FAIL lk_op4 got %b L%b exp 0100 L1", gnt, locked); end
      step;
      req = 4'b1001; #1;
      checks++; if (gnt !== 4'b1000 || locked !== 1'b0) begin errors++; $display("FAIL lk_after3 got %b L%b exp 1000 L0", gnt, locked); end
      step;
      req = 4'b0001; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL lk_after0 got %b exp 0001", gnt); end
      step;
      req = '0;
   endtask

   task automatic test_lock_timeout;
      do_reset;
      for (int i = 0; i < 4; i++) set_lane(i, 16'h0400 + 16'(i), 16'h0000, 16'd1, 16'd1);
      req = 4'b0010; req_lock = 4'b0010; #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_gnt got %b exp 0010", gnt); end
      step;
      req = 4'b0001;
      for (int k = 0; k < 15; k++) begin
         #1;
         checks++; if (gnt !== 4'b0000 || locked !== 1'b1)
            begin errors++; $display("FAIL to_idle k%0d got %b L%b exp 0000 L1", k, gnt, locked); end
         step;
      end
      #1;
      checks++; if (locked !== 1'b0 || gnt !== 4'b0001) begin errors++; $display("FAIL to_release got %b L%b exp 0001 L0", gnt, locked); end
      step;
      // Owner's last op lands on the cycle the timeout would fire
      req = 4'b0010; req_lock = 4'b0010; #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to2_gnt got %b exp 0010", gnt); end
      step;
      req = 4'b0001;
      for (int k = 0; k < 14; k++) step;
      req = 4'b0011; req_lock = 4'b0000; #1;
      checks++; if (gnt !== 4'b0010 || locked !== 1'b1) begin errors++; $display("FAIL to2_race got %b L%b exp 0010 L1", gnt, locked); end
      step;
      req = 4'b0001; #1;
      checks++; if (gnt !== 4'b0001 || locked !== 1'b0) begin errors++; $display("FAIL to2_after got %b L%b exp 0001 L0", gnt, locked); end
      step;
      req = '0;
   endtask

   task automatic test_reset_midflight;
      do_reset;
      set_lane(0, 16'h0500, 16'h0000, 16'd8, 16'd8);
      req = 4'b0001; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mr_gnt got %b exp 0001", gnt); end
      step;
      req = '0; reset = 1'b1; #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_v1 got %b exp 0", rsp_valid); end
      step;
      reset = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_v2 got %b exp 0", rsp_valid); end
      step;
      checks++; if (rsp_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL mr_v3 got v%b L%b exp v0 L0", rsp_valid, locked); end
      req = 4'b1111; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mr_ptr got %b exp 0001", gnt); end
      step;
      req = '0;
   endtask

   task automatic test_idle_and_sub;
      do_reset;
      for (int i = 0; i < 4; i++) set_lane(i, 16'h0600, 16'h0007, 16'h1234, 16'h4321);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (gnt !== 4'b0000 || alu_ins !== 16'h0 || alu_op1 !== 16'h0 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL idle c%0d got %b %h %h v%b exp 0000 0000 0000 v0", c, gnt, alu_ins, alu_op1, rsp_valid); end
         step;
      end
      set_lane(3, 16'h0603, 16'h0001, 16'd2, 16'd5);
      req = 4'b1000; #1;
      checks++; if (gnt !== 4'b1000 || alu_ins !== 16'h0001) begin errors++; $display("FAIL sub_gnt got %b %h exp 1000 0001", gnt, alu_ins); end
      step; req = '0;
      step;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'hFFFD)
         begin errors++; $display("FAIL sub_rsp got v%b id%0d %h exp v1 id3 fffd", rsp_valid, rsp_id, rsp_data); end
   endtask

   initial begin
      reset = 1'b1; req = '0; req_lock = '0;
      req_pc = '0; req_ins = '0; req_op1 = '0; req_op2 = '0;
      step;
      test_reset;
      test_single_add;
      test_round_robin;
      test_lock_chain;
      test_lock_timeout;
      test_reset_midflight;
      test_idle_and_sub;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
